// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder
//   Memory-side responder for the Ibex req/gnt/rvalid/err bus. Holds a
//   word-addressed RAM and answers each accepted transaction after a fixed
//   latency. The grant stall, the response latency and the outstanding limit
//   are parameters, so one block can exercise a core's stall paths.
//
// Ports
//   clk_i, rst_ni    clock (rising edge), asynchronous active-low reset
//   req_i / gnt_o    request valid / accepted this cycle (combinational)
//   we_i, be_i       write enable, byte enables (bit n = byte lane n)
//   addr_i, wdata_i  byte address (bits [1:0] ignored), write data
//   rvalid_o         one-cycle response pulse per transaction
//   rdata_o, err_o   read data / error flag, both zero when rvalid_o=0
module ibex_mem_responder #(
   parameter int unsigned MemWords       = 1024,
   parameter logic [31:0] BaseAddr       = 32'h0000_0000,
   parameter int unsigned GntStallCycles = 0,
   parameter int unsigned RespLatency    = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned AW = $clog2(MemWords);

   typedef struct packed {
      logic        vld;
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   logic [3:0]  stall_cnt_q, stall_cnt_d;
   logic [3:0]  outst_q, outst_d, outst_eff;
   resp_t       pipe_q [RespLatency];
   resp_t       resp_new;
   logic [31:0] mem_q [MemWords];
   logic [31:0] offset;
   logic        in_range;
   logic [AW-1:0] word_idx;
   logic        accept;
   logic        unused_off;

   // Subtracting the base lets one unsigned compare cover both bounds:
   // addresses below BaseAddr wrap to large offsets.
   assign offset     = addr_i - BaseAddr;
   assign in_range   = (offset[31:AW+2] == '0);
   assign word_idx   = offset[AW+1:2];
   assign unused_off = ^offset[1:0];

   // An entry retiring this cycle frees its slot immediately, so the grant
   // sees the count after retirement.
   assign outst_eff = outst_q - {3'b000, rvalid_o};
   assign gnt_o     = rst_ni & req_i
                    & (stall_cnt_q == 4'(GntStallCycles))
                    & (outst_eff < 4'(MaxOutstanding));
   assign accept    = req_i & gnt_o;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!req_i || gnt_o) begin
         stall_cnt_d = '0;
      end else if (stall_cnt_q != 4'(GntStallCycles)) begin
         stall_cnt_d = stall_cnt_q + 4'd1;
      end
   end

   assign outst_d = outst_q + {3'b000, accept} - {3'b000, rvalid_o};

   // Response formed at acceptance; the RAM read sees all earlier writes.
   always_comb begin
      resp_new = '0;
      if (accept) begin
         resp_new.vld = 1'b1;
         if (!in_range) begin
            resp_new.err = 1'b1;
         end else if (!we_i) begin
            resp_new.rdata = mem_q[word_idx];
         end
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk_i) begin
      if (accept && we_i && in_range) begin
         for (int n = 0; n < 4; n++) begin
            if (be_i[n]) mem_q[word_idx][8*n +: 8] <= wdata_i[8*n +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         outst_q     <= '0;
         for (int i = 0; i < int'(RespLatency); i++) pipe_q[i] <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         outst_q     <= outst_d;
         pipe_q[0]   <= resp_new;
         for (int i = 1; i < int'(RespLatency); i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign rvalid_o = pipe_q[RespLatency-1].vld;
   assign err_o    = pipe_q[RespLatency-1].vld & pipe_q[RespLatency-1].err;
   assign rdata_o  = pipe_q[RespLatency-1].vld ? pipe_q[RespLatency-1].rdata : 32'h0;

`ifndef SYNTHESIS
   a_rvalid_outst: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    rvalid_o |-> (outst_q != 4'd0));
   a_outst_max:    assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    outst_q <= 4'(MaxOutstanding));
   a_gnt_req:      assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    gnt_o |-> req_i);
`endif

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for ibex_mem_responder. Four instances with different parameter sets
// share one clock; tests run one instance at a time. Stimulus pushes the
// expected response (instance, err, rdata, cycle) into a scoreboard queue and
// a monitor pops and compares on every rvalid.
module tb_ibex_mem_responder;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n [N];
   logic        req   [N];
   logic        gnt   [N];
   logic        we    [N];
   logic [3:0]  be    [N];
   logic [31:0] addr  [N];
   logic [31:0] wdata [N];
   logic        rvalid[N];
   logic [31:0] rdata [N];
   logic        err   [N];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          inst;
      bit          err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 0: defaults   1: grant stall 3   2: latency 4, limit 2   3: latency 3
   ibex_mem_responder u0 (
      .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]),
      .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .err_o(err[0]));
   ibex_mem_responder #(.GntStallCycles(3)) u1 (
      .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]),
      .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .err_o(err[1]));
   ibex_mem_responder #(.RespLatency(4), .MaxOutstanding(2)) u2 (
      .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]),
      .be_i(be[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
      .rdata_o(rdata[2]), .err_o(err[2]));
   ibex_mem_responder #(.RespLatency(3)) u3 (
      .clk_i(clk), .rst_ni(rst_n[3]), .req_i(req[3]), .gnt_o(gnt[3]), .we_i(we[3]),
      .be_i(be[3]), .addr_i(addr[3]), .wdata_i(wdata[3]), .rvalid_o(rvalid[3]),
      .rdata_o(rdata[3]), .err_o(err[3]));

   function automatic int lat_of(input int i);
      case (i)
         2:       return 4;
         3:       return 3;
         default: return 1;
      endcase
   endfunction

   // Monitor: every response must match the oldest expectation.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rvalid[i]) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_rvalid inst=%0d cyc=%0d rdata=%h err=%0b",
                        i, cyc, rdata[i], err[i]);
            end else begin
               e = sb.pop_front();
               if (e.inst != i || e.err != err[i] || e.rdata !== rdata[i] || e.cyc != cyc) begin
                  bad++;
                  $display("FAIL resp got inst=%0d cyc=%0d err=%0b rdata=%h want inst=%0d cyc=%0d err=%0b rdata=%h",
                           i, cyc, err[i], rdata[i], e.inst, e.cyc, e.err, e.rdata);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Drive one request starting at posedge+1; returns at posedge+1 after the
   // grant with req still high so calls can run back-to-back.
   task automatic xact(input int i, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit eerr, input logic [31:0] erd, input bit push,
                       output int gcyc);
      exp_t x;
      req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = wd;
      gcyc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (gnt[i]) begin
            gcyc = cyc;
            if (push) begin
               x.inst = i; x.err = eerr; x.rdata = erd; x.cyc = cyc + lat_of(i);
               sb.push_back(x);
            end
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      if (gcyc < 0) begin
         total++; bad++;
         $display("FAIL grant_timeout inst=%0d addr=%h got=no_gnt want=gnt", i, a);
      end
   endtask

   task automatic idle(input int i);
      req[i] = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sb.size() > 0; k++) @(posedge clk);
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout got=%0d want=0 pending", sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   int g, g0, g1, g2, g3, c0;

   initial begin
      for (int i = 0; i < N; i++) begin
         rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0;
         addr[i] = '0; wdata[i] = '0;
      end
      req[0] = 1'b1;
      @(negedge clk);
      chk("rst_gnt", {31'b0, gnt[0]}, 32'h0);
      for (int i = 0; i < N; i++) begin
         chk("rst_rvalid", {31'b0, rvalid[i]}, 32'h0);
         chk("rst_err",    {31'b0, err[i]},    32'h0);
         chk("rst_rdata",  rdata[i],           32'h0);
      end
      req[0] = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
      @(posedge clk); #1;

      // Basic write then read, same-cycle grant, back-to-back read-after-write.
      c0 = cyc;
      xact(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1, g0);
      xact(0, 0, 4'hF, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1, g1);
      xact(0, 0, 4'h0, 32'h13, 32'h0, 0, 32'hDEADBEEF, 1, g);   // low bits and be ignored
      idle(0);
      chk("basic_gnt0", g0, c0);
      chk("basic_gnt1", g1, c0 + 1);
      drain();

      // Partial byte enables, be=0 write leaves word alone.
      xact(0, 1, 4'hF, 32'h20, 32'h11223344, 0, 32'h0, 1, g);
      xact(0, 1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, 32'h0, 1, g);
      xact(0, 0, 4'hF, 32'h20, 32'h0, 0, 32'h11BB33DD, 1, g);
      xact(0, 1, 4'h0, 32'h20, 32'hFFFFFFFF, 0, 32'h0, 1, g);
      xact(0, 0, 4'hF, 32'h20, 32'h0, 0, 32'h11BB33DD, 1, g);
      idle(0);
      drain();

      // Error responses; the out-of-range write must not alias onto word 0.
      xact(0, 1, 4'hF, 32'h0, 32'h0BADF00D, 0, 32'h0, 1, g);
      xact(0, 1, 4'hF, 32'h1000, 32'hFFFFFFFF, 1, 32'h0, 1, g);
      xact(0, 0, 4'hF, 32'h1000, 32'h0, 1, 32'h0, 1, g);
      xact(0, 0, 4'hF, 32'h0, 32'h0, 0, 32'h0BADF00D, 1, g);
      xact(0, 1, 4'hF, 32'hFFC, 32'h12345678, 0, 32'h0, 1, g);   // last word
      xact(0, 0, 4'hF, 32'hFFC, 32'h0, 0, 32'h12345678, 1, g);
      xact(0, 0, 4'hF, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1, g);
      idle(0);
      drain();

      // Grant stall of 3 cycles with req held.
      c0 = cyc;
      xact(1, 1, 4'hF, 32'h40, 32'h5A5A0F0F, 0, 32'h0, 1, g);
      idle(1);
      chk("stall_held_gnt", g, c0 + 3);
      drain();
      // Drop req in cycle 1, re-raise in cycle 2: counter restarts.
      c0 = cyc;
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40;
      @(negedge clk);
      chk("stall_no_early_gnt", {31'b0, gnt[1]}, 32'h0);
      @(posedge clk); #1;
      req[1] = 1'b0;
      @(posedge clk); #1;
      xact(1, 0, 4'hF, 32'h40, 32'h0, 0, 32'h5A5A0F0F, 1, g);
      idle(1);
      chk("stall_drop_gnt", g, c0 + 5);
      drain();

      // Latency 4 with outstanding limit 2.
      for (int k = 0; k < 4; k++) begin
         xact(2, 1, 4'hF, 32'(k * 4), 32'hC0DE0000 + 32'(k), 0, 32'h0, 1, g);
      end
      idle(2);
      drain();
      c0 = cyc;
      xact(2, 0, 4'hF, 32'h0, 32'h0, 0, 32'hC0DE0000, 1, g0);
      xact(2, 0, 4'hF, 32'h4, 32'h0, 0, 32'hC0DE0001, 1, g1);
      xact(2, 0, 4'hF, 32'h8, 32'h0, 0, 32'hC0DE0002, 1, g2);
      xact(2, 0, 4'hF, 32'hC, 32'h0, 0, 32'hC0DE0003, 1, g3);
      idle(2);
      chk("lim_gnt0", g0, c0);
      chk("lim_gnt1", g1, c0 + 1);
      chk("lim_gnt2", g2, c0 + 4);
      chk("lim_gnt3", g3, c0 + 5);
      drain();

      // Reset mid-flight, latency 3: the in-flight read must vanish.
      xact(3, 1, 4'hF, 32'h0, 32'hCAFEF00D, 0, 32'h0, 1, g);
      idle(3);
      drain();
      c0 = cyc;
      xact(3, 0, 4'hF, 32'h0, 32'h0, 0, 32'h0, 0, g);
      chk("rst_flight_gnt", g, c0);
      rst_n[3] = 1'b0;
      @(negedge clk);
      chk("rst_flight_gnt_low", {31'b0, gnt[3]}, 32'h0);
      req[3] = 1'b0;
      rst_n[3] = 1'b1;
      while (cyc <= c0 + 6) @(posedge clk);
      #1;
      c0 = cyc;
      xact(3, 0, 4'hF, 32'h0, 32'h0, 0, 32'hCAFEF00D, 1, g);
      idle(3);
      chk("rst_after_gnt", g, c0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1);
   end

endmodule
